// File: rtl/shift_unit_iter.sv
// Iterative 32-bit shifter: one fixed-distance barrel stage per cycle (16/8/4/2/1),
// with a start/ready request side and a valid/ack result side.
module shift_unit_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   data_in_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic [WIDTH-1:0]   result_o,
    output logic               result_valid_o,
    input  logic               result_ack_i
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;

    generate
        if (WIDTH != (1 << SHAMT_W)) begin : g_param_check
            $error("shift_unit_iter: WIDTH must equal 2**SHAMT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [1:0]           op_q, op_d;
    logic [SHAMT_W-1:0]   stage_q, stage_d;
    logic [WIDTH-1:0]     result_q, result_d;

    // Candidate value of the working register for every stage; the stage
    // counter picks one per cycle. An unselected shamt bit holds the value.
    logic [SHAMT_W-1:0][WIDTH-1:0] stage_val;
    logic [WIDTH-1:0]              shifted;

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int DIST = 1 << gi;
            assign stage_val[gi] = !shamt_q[gi]     ? data_q :
                                   (op_q == OP_SLL) ? (data_q << DIST) :
                                   (op_q == OP_SRA) ? WIDTH'($signed(data_q) >>> DIST) :
                                   (op_q == OP_SRL) ? (data_q >> DIST) :
                                                      data_q;
        end
    endgenerate

    always_comb begin
        shifted = data_q;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (stage_q == SHAMT_W'(i)) begin
                shifted = stage_val[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        shamt_d        = shamt_q;
        op_d           = op_q;
        stage_d        = stage_q;
        result_d       = result_q;
        ready_o        = 1'b0;
        busy_o         = 1'b0;
        result_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    data_d  = data_in_i;
                    shamt_d = shamt_i;
                    op_d    = op_i;
                    stage_d = SHAMT_W'(SHAMT_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_o = 1'b1;
                data_d = shifted;
                if (stage_q == '0) begin
                    result_d = shifted;
                    state_d  = DONE;
                end else begin
                    stage_d = stage_q - 1'b1;
                end
            end
            DONE: begin
                result_valid_o = 1'b1;
                // start is deliberately ignored here even when ack arrives.
                if (result_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            data_q   <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            stage_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            stage_q  <= stage_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule
